instr_register_exec: RTL and testbench

Responder side of the instruction-register write/read protocol: a 32-entry instruction store that accepts write transactions from the stimulus side, computes each entry's 64-bit result on a shared multi-cycle execution engine, and serves read transactions with a valid handshake once the result is ready. It sits where the plain instruction register sits today and adds real execution latency. Reads stall until the result is ready.

---
 rtl/instr_register_pkg.sv | 23 ++
 rtl/instr_register_exec_if.sv | 17 +
 rtl/seq_divider.sv | 45 ++++
 rtl/instr_register_exec.sv | 141 ++++++++++++++
 tb/tb_instr_register_exec.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared types for the executing instruction register
package instr_register_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int PEND_DEPTH_DEFAULT = 4;
    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [ADDR_WIDTH-1:0] address_t;
    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_WB} exec_state_t;
    typedef struct packed {
        opcode_t opc;
        operand_t op_a;
        operand_t op_b;
        result_t rezultat;
    } instruction_t;
    function automatic result_t alu(opcode_t opc, operand_t a, operand_t b);
        result_t x, y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return opc == PASSA ? x : opc == PASSB ? y : opc == ADD ? x + y :
               opc == SUB ? x - y : opc == MULT ? x * y : '0;
    endfunction
endpackage

// File: rtl/instr_register_exec_if.sv
// instr_register_exec_if: write/read transaction bus between stimulus (master) and responder (slave)
interface instr_register_exec_if;
    import instr_register_pkg::*;
    logic load_en, load_ready, read_en, read_valid, busy;
    address_t write_pointer, read_pointer;
    opcode_t opcode;
    operand_t operand_a, operand_b;
    instruction_t instruction_word;
    modport master(
        output load_en, write_pointer, opcode, operand_a, operand_b, read_en, read_pointer,
        input load_ready, read_valid, instruction_word, busy
    );
    modport slave(
        input load_en, write_pointer, opcode, operand_a, operand_b, read_en, read_pointer,
        output load_ready, read_valid, instruction_word, busy
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative signed 32/32 restoring divider on magnitudes, one quotient bit per cycle;
// div_done is high during the cycle whose closing edge performs the 32nd iteration.
module seq_divider
    import instr_register_pkg::*;
(
    input logic clk,
    input logic reset,
    input logic start,
    input operand_t a,
    input operand_t b,
    output logic div_done,
    output result_t quotient,
    output result_t remainder
);
    logic run, neg_q, neg_r, zero;
    logic [4:0] cnt;
    logic [31:0] q, d;
    logic [32:0] r, t;

    assign t = {r[31:0], q[31]};
    assign div_done = run && cnt == 5'd31;
    assign quotient = zero ? '0 : neg_q ? -{32'd0, q} : {32'd0, q};
    assign remainder = zero ? '0 : neg_r ? -{32'd0, r[31:0]} : {32'd0, r[31:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            q <= a[31] ? -a : a;
            d <= b[31] ? -b : b;
            r <= '0;
            neg_q <= a[31] ^ b[31];
            neg_r <= a[31];
            zero <= b == 0;
        end else if (run) begin
            cnt <= cnt + 5'd1;
            run <= cnt != 5'd31;
            r <= t >= {1'b0, d} ? t - {1'b0, d} : t;
            q <= {q[30:0], t >= {1'b0, d}};
        end
    end
endmodule

// File: rtl/instr_register_exec.sv
// instr_register_exec: 32-entry instruction store; results come from a shared multi-cycle
// engine fed by a FIFO of {index, gen} tags, and reads stall until the entry is done.
module instr_register_exec
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int PEND_DEPTH = PEND_DEPTH_DEFAULT
) (
    input logic clk,
    input logic reset,
    instr_register_exec_if.slave bus
);
    localparam int N = 1 << ADDR_W;
    localparam int PW = PEND_DEPTH > 1 ? $clog2(PEND_DEPTH) : 1;
    localparam int CW = $clog2(PEND_DEPTH + 1);

    opcode_t opc_m [N];
    operand_t a_m [N];
    operand_t b_m [N];
    result_t res_m [N];
    logic [N-1:0] valid, done, gen;
    address_t fifo_idx [PEND_DEPTH];
    logic [PEND_DEPTH-1:0] fifo_gen;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    exec_state_t state, state_nx;
    address_t cur_idx, head_idx, sel, rd_idx;
    opcode_t cur_opc;
    operand_t cur_a, cur_b;
    logic cur_gen, killed, is_div, we, pop, start, wb, wb_ok, div_done, full, ready, rd_pend, rvalid;
    result_t quo, rem, wb_res;
    instruction_t word, rword;

    assign full = count == CW'(PEND_DEPTH);
    assign we = bus.load_en && bus.load_ready;
    assign head_idx = fifo_idx[rd_ptr];
    assign is_div = cur_opc == DIV || cur_opc == MOD;
    assign wb_ok = wb && gen[cur_idx] == cur_gen && !killed;
    assign bus.load_ready = !full && !reset;
    assign bus.busy = count != '0 || state != S_IDLE;
    assign bus.read_valid = rvalid;
    assign bus.instruction_word = rword;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (we) begin
                fifo_idx[wr_ptr] <= bus.write_pointer;
                fifo_gen[wr_ptr] <= !gen[bus.write_pointer];
                wr_ptr <= wr_ptr == PW'(PEND_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr == PW'(PEND_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(we) - CW'(pop);
        end
    end

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_nx;

    always_comb begin
        state_nx = state == S_IDLE ? (count != '0 && fifo_gen[rd_ptr] == gen[head_idx] ? S_EXEC : S_IDLE)
                 : state == S_EXEC ? (is_div ? S_DIV : S_IDLE)
                 : state == S_DIV ? (div_done ? S_WB : S_DIV) : S_IDLE;
    end

    always_comb begin
        pop = state == S_IDLE && count != '0;
        start = state == S_EXEC && is_div;
        wb = (state == S_EXEC && !is_div) || state == S_WB;
        wb_res = state == S_WB ? (cur_opc == DIV ? quo : rem) : alu(cur_opc, cur_a, cur_b);
    end

    // Two overwrites during one execution restore the gen bit, so writes since pop are tracked too.
    always_ff @(posedge clk) begin
        if (pop) begin
            cur_idx <= head_idx;
            cur_gen <= fifo_gen[rd_ptr];
            cur_opc <= opc_m[head_idx];
            cur_a <= a_m[head_idx];
            cur_b <= b_m[head_idx];
            killed <= we && bus.write_pointer == head_idx;
        end else if (we && bus.write_pointer == cur_idx)
            killed <= 1'b1;
    end

    seq_divider u_div (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(cur_a),
        .b(cur_b),
        .div_done(div_done),
        .quotient(quo),
        .remainder(rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            done <= '0;
            gen <= '0;
        end else begin
            if (wb_ok) begin
                res_m[cur_idx] <= wb_res;
                done[cur_idx] <= 1'b1;
            end
            if (we) begin
                opc_m[bus.write_pointer] <= bus.opcode;
                a_m[bus.write_pointer] <= bus.operand_a;
                b_m[bus.write_pointer] <= bus.operand_b;
                res_m[bus.write_pointer] <= '0;
                valid[bus.write_pointer] <= 1'b1;
                done[bus.write_pointer] <= 1'b0;
                gen[bus.write_pointer] <= !gen[bus.write_pointer];
            end
        end
    end

    assign sel = rd_pend ? rd_idx : bus.read_pointer;
    assign ready = (done[sel] || !valid[sel]) && !(we && bus.write_pointer == sel);
    assign word = valid[sel] ? {opc_m[sel], a_m[sel], b_m[sel], res_m[sel]} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rvalid <= 1'b0;
            rword <= '0;
        end else begin
            rvalid <= (rd_pend || bus.read_en) && ready;
            rd_pend <= (rd_pend || bus.read_en) && !ready;
            if ((rd_pend || bus.read_en) && ready)
                rword <= word;
            if (!rd_pend)
                rd_idx <= bus.read_pointer;
        end
    end
endmodule

// File: tb/tb_instr_register_exec.sv
// tb_instr_register_exec: directed latency/boundary cases plus random traffic checked
// against an arithmetic model of each entry's latest write.
module tb_instr_register_exec;
    import instr_register_pkg::*;
    logic clk, reset;
    instr_register_exec_if bus();
    instr_register_exec dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    bit m_valid [32];
    opcode_t m_opc [32];
    operand_t m_a [32];
    operand_t m_b [32];

    task automatic check(input string tag, input logic [130:0] got, input logic [130:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instruction_t exp_word(int i);
        instruction_t w;
        longint x, y, r;
        w = '0;
        if (!m_valid[i]) return w;
        x = m_a[i];
        y = m_b[i];
        case (m_opc[i])
            PASSA: r = x;
            PASSB: r = y;
            ADD: r = x + y;
            SUB: r = x - y;
            MULT: r = x * y;
            DIV: r = y == 0 ? 0 : x / y;
            MOD: r = y == 0 ? 0 : x % y;
            default: r = 0;
        endcase
        w.opc = m_opc[i];
        w.op_a = m_a[i];
        w.op_b = m_b[i];
        w.rezultat = r;
        return w;
    endfunction

    function automatic operand_t rnd_op();
        int k;
        k = $urandom_range(0, 7);
        return k < 4 ? operand_t'($urandom_range(0, 40)) - 20 : k < 7 ? operand_t'($urandom) : 32'sh80000000;
    endfunction

    // One cycle of optional write and optional read; with a read, waits up to limit cycles for read_valid.
    task automatic xact(input bit w, input int wi, input opcode_t o, input operand_t a, input operand_t b,
                        input bit r, input int ri, input int limit,
                        output bit acc, output bit seen, output int lat, output instruction_t got);
        bus.load_en = w;
        bus.write_pointer = address_t'(wi);
        bus.opcode = o;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.read_en = r;
        bus.read_pointer = address_t'(ri);
        acc = w && bus.load_ready;
        tick();
        bus.load_en = 0;
        bus.read_en = 0;
        if (acc) begin
            m_valid[wi] = 1;
            m_opc[wi] = o;
            m_a[wi] = a;
            m_b[wi] = b;
        end
        seen = 0;
        lat = 0;
        got = '0;
        if (r) begin
            while (!bus.read_valid && lat < limit) begin
                tick();
                lat++;
            end
            seen = bus.read_valid;
            got = bus.instruction_word;
        end
    endtask

    bit acc, seen;
    int lat, nv, idx, ri;
    opcode_t o;
    operand_t a, b;
    instruction_t got, held;
    opcode_t t2_opc [3] = '{DIV, MOD, DIV};
    int t2_b [3] = '{2, 2, 0};
    longint t2_exp [3] = '{-3, -1, 0};

    initial begin
        bus.load_en = 0;
        bus.read_en = 0;
        bus.write_pointer = '0;
        bus.read_pointer = '0;
        bus.opcode = ZERO;
        bus.operand_a = 0;
        bus.operand_b = 0;
        for (int i = 0; i < 32; i++) m_valid[i] = 0;
        reset = 1;
        tick();
        tick();
        check("rst_load_ready", bus.load_ready, 0);
        check("rst_read_valid", bus.read_valid, 0);
        check("rst_word", bus.instruction_word, 0);
        check("rst_busy", bus.busy, 0);
        reset = 0;
        tick();
        check("post_rst_load_ready", bus.load_ready, 1);

        xact(1, 0, ADD, 5, 3, 0, 0, 0, acc, seen, lat, got);
        check("add_acc", acc, 1);
        repeat (4) tick();
        xact(0, 0, ZERO, 0, 0, 1, 0, 20, acc, seen, lat, got);
        check("add_lat", lat, 0);
        check("add_rez", got.rezultat, 64'sd8);
        check("add_word", got, exp_word(0));
        held = got;
        tick();
        check("hold_valid", bus.read_valid, 0);
        check("hold_word", bus.instruction_word, held);

        xact(1, 3, MULT, -6, 7, 1, 3, 20, acc, seen, lat, got);
        check("mult_lat", lat, 3);
        check("mult_rez", got.rezultat, -64'sd42);

        for (int i = 0; i < 3; i++) begin
            xact(1, 1, t2_opc[i], -7, t2_b[i], 1, 1, 100, acc, seen, lat, got);
            check("div_lat", lat, 36);
            check("div_rez", got.rezultat, t2_exp[i]);
            check("div_word", got, exp_word(1));
        end

        xact(1, 2, DIV, 100, 7, 0, 0, 0, acc, seen, lat, got);
        repeat (5) tick();
        xact(1, 2, SUB, 1, 4, 1, 2, 200, acc, seen, lat, got);
        check("ovw_seen", seen, 1);
        check("ovw_rez", got.rezultat, -64'sd3);
        check("ovw_word", got, exp_word(2));

        xact(0, 0, ZERO, 0, 0, 1, 31, 20, acc, seen, lat, got);
        check("nw_lat", lat, 0);
        check("nw_word", got, 0);

        for (int i = 0; i < 8; i++) begin
            xact(1, i < 5 ? 10 + i : 15, DIV, rnd_op(), rnd_op(), 0, 0, 0, acc, seen, lat, got);
            check("full_acc", acc, i < 5);
        end
        check("full_ready", bus.load_ready, 0);
        xact(0, 0, ZERO, 0, 0, 1, 15, 20, acc, seen, lat, got);
        check("full_dropped_lat", lat, 0);
        check("full_dropped_word", got, 0);
        for (int i = 10; i < 15; i++) begin
            xact(0, 0, ZERO, 0, 0, 1, i, 400, acc, seen, lat, got);
            check("full_seen", seen, 1);
            check("full_word", got, exp_word(i));
        end

        xact(1, 5, DIV, 50, 3, 1, 5, 10, acc, seen, lat, got);
        check("rst_mid_stall", seen, 0);
        check("rst_mid_busy", bus.busy, 1);
        reset = 1;
        tick();
        check("rst_mid_ready", bus.load_ready, 0);
        tick();
        reset = 0;
        for (int i = 0; i < 32; i++) m_valid[i] = 0;
        nv = 0;
        repeat (50) begin
            tick();
            nv += int'(bus.read_valid);
        end
        check("rst_mid_no_valid", nv, 0);
        check("rst_mid_idle", bus.busy, 0);
        xact(0, 0, ZERO, 0, 0, 1, 5, 20, acc, seen, lat, got);
        check("rst_mid_lat", lat, 0);
        check("rst_mid_word", got, 0);

        for (int it = 0; it < 200; it++) begin
            idx = $urandom_range(0, 7);
            o = opcode_t'($urandom_range(0, 7));
            a = rnd_op();
            b = rnd_op();
            if ($urandom_range(0, 3) != 0)
                xact(1, idx, o, a, b, 0, 0, 0, acc, seen, lat, got);
            else begin
                ri = $urandom_range(0, 7);
                xact(1'($urandom_range(0, 1)), idx, o, a, b, 1, ri, 400, acc, seen, lat, got);
                check("rnd_seen", seen, 1);
                check("rnd_word", got, exp_word(ri));
            end
        end
        repeat (250) tick();
        check("drain_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
